// File: rtl/mopshub_gen_pkg.sv
// Shared types and frame layout for the multi-bus uplink frame generator.
package mopshub_gen_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SIGNON = 3'd1,
    LOAD   = 3'd2,
    IRQ    = 3'd3,
    READ   = 3'd4,
    ACK    = 3'd5,
    NEXT   = 3'd6,
    DONE   = 3'd7
  } state_t;

  localparam int PAYLOAD_W = 76;
  localparam int BUS_LSB   = 71;
  localparam int BUS_W     = 5;
  localparam int COB_LSB   = 60;
  localparam int COB_W     = 11;
  localparam int DLC_LSB   = 56;
  localparam int DLC_W     = 4;

  localparam logic [3:0]  DLC_VAL = 4'd8;
  localparam logic [7:0]  SDO_CMD = 8'h40;
  localparam logic [15:0] SDO_IDX = 16'h1000;

  // Low 56 bits are an SDO-style expedited write carrying the sequence number.
  function automatic logic [PAYLOAD_W-1:0] build_payload(input logic [BUS_W-1:0] bus,
                                                         input logic [COB_W-1:0] cob,
                                                         input logic [15:0]      seq);
    return {bus, cob, DLC_VAL, SDO_CMD, SDO_IDX, 8'h00, 8'h00, seq};
  endfunction

endpackage

// File: rtl/mopshub_gen_timer.sv
// Wait-state timeout counter: clr restarts the count in the same cycle,
// expire is high in the LIMIT-th consecutive cycle that run is held.
module mopshub_gen_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cur;

  assign cur    = clr ? '0 : cnt;
  assign expire = run && (cur == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cur + W'(1);
    end
  end

endmodule

// File: rtl/mopshub_frame_gen.sv
// Uplink frame generator: sign-on sweep, then per-frame elink handshake with
// mopshubCore, holding each frame until the CAN transmission is reported done.
//
// Handshake: irq_elink is a level "frame valid"; it stays high and payload stays
// stable until the core answers with start_read_elink. end_read_elink and
// end_send_msg are single-cycle completions, honoured only in the state that
// waits for them (simultaneous completions are folded forward).
module mopshub_frame_gen
  import mopshub_gen_pkg::*;
#(
  parameter int         N_BUS       = 8,
  parameter int         N_FRAMES    = 16,
  parameter logic [6:0] NODE_ID     = 7'h01,
  parameter int         MODE        = 0,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        loop_en,
  input  logic [4:0]  bus_fixed,
  input  logic        en,
  input  logic        start_read_elink,
  input  logic        end_read_elink,
  input  logic        end_send_msg,
  output logic        sign_on_sig,
  output logic        irq_elink,
  output logic [75:0] payload,
  output logic [11:0] canid,
  output logic [4:0]  bus_sel,
  output logic [15:0] frame_cnt,
  output logic        done,
  output logic        err_timeout,
  output state_t      state
);

  localparam logic [10:0] COB      = 11'h600 + {4'd0, NODE_ID};
  localparam logic [4:0]  LAST_BUS = 5'(N_BUS - 1);
  localparam logic [15:0] NF       = 16'(N_FRAMES);

  state_t     state_q;
  logic [4:0] fixed_bus;
  logic [4:0] first_bus;
  logic [4:0] next_bus;
  logic       wait_st;
  logic       entry;
  logic       expire;

  always_comb begin
    fixed_bus = 5'(({27'd0, bus_fixed}) % 32'(N_BUS));
    first_bus = (MODE == 1) ? fixed_bus : 5'd0;
    if (MODE == 1) begin
      next_bus = fixed_bus;
    end else begin
      next_bus = (bus_sel == LAST_BUS) ? 5'd0 : bus_sel + 5'd1;
    end
  end

  assign wait_st = (state == IRQ) || (state == READ) || (state == ACK);
  assign entry   = (state != state_q);

  mopshub_gen_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (entry),
    .run    (wait_st),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      state_q     <= IDLE;
      sign_on_sig <= 1'b0;
      irq_elink   <= 1'b0;
      payload     <= '0;
      canid       <= '0;
      bus_sel     <= '0;
      frame_cnt   <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state;
      sign_on_sig <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            frame_cnt   <= '0;
            err_timeout <= 1'b0;
            bus_sel     <= '0;
            done        <= 1'b0;
            sign_on_sig <= 1'b1;
            state       <= SIGNON;
          end
        end
        SIGNON: begin
          if (bus_sel == LAST_BUS) begin
            bus_sel <= first_bus;
            state   <= LOAD;
          end else begin
            bus_sel     <= bus_sel + 5'd1;
            sign_on_sig <= 1'b1;
          end
        end
        LOAD: begin
          payload <= build_payload(bus_sel, COB, frame_cnt);
          canid   <= {1'b0, COB};
          if (en) begin
            irq_elink <= 1'b1;
            state     <= IRQ;
          end
        end
        IRQ: begin
          if (start_read_elink) begin
            irq_elink <= 1'b0;
            state     <= end_read_elink ? ACK : READ;
          end else if (expire) begin
            err_timeout <= 1'b1;
            irq_elink   <= 1'b0;
            state       <= LOAD;
          end
        end
        READ: begin
          if (end_read_elink) begin
            if (end_send_msg) begin
              frame_cnt <= frame_cnt + 16'd1;
              state     <= NEXT;
            end else begin
              state <= ACK;
            end
          end else if (expire) begin
            err_timeout <= 1'b1;
            state       <= LOAD;
          end
        end
        ACK: begin
          if (end_send_msg) begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= NEXT;
          end else if (expire) begin
            err_timeout <= 1'b1;
            state       <= LOAD;
          end
        end
        NEXT: begin
          if (frame_cnt == NF) begin
            if (loop_en) begin
              frame_cnt <= '0;
              bus_sel   <= first_bus;
              state     <= LOAD;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            bus_sel <= next_bus;
            state   <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mopshub_frame_gen.sv
// Directed bench for mopshub_frame_gen: three instances cover round-robin with a
// short timeout, fixed-bus mode and loop mode, driven by a simple core model.
module tb_mopshub_frame_gen;
  import mopshub_gen_pkg::*;

  localparam int NI = 3;

  logic        clk;
  logic        rst;
  logic        en;
  logic        loop_en;
  logic [4:0]  bus_fixed;
  logic        start_v [NI];
  logic        srd_v   [NI];
  logic        erd_v   [NI];
  logic        esm_v   [NI];
  logic        so_v    [NI];
  logic        irq_v   [NI];
  logic [75:0] pay_v   [NI];
  logic [11:0] canid_v [NI];
  logic [4:0]  bus_v   [NI];
  logic [15:0] fcnt_v  [NI];
  logic        done_v  [NI];
  logic        err_v   [NI];
  state_t      st_v    [NI];

  int n_cmp = 0;
  int n_err = 0;
  int so_cnt2 = 0;
  logic [4:0]  exp_q[$];
  logic [15:0] seq_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mopshub_frame_gen #(.TIMEOUT_CYC(16)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .loop_en(loop_en), .bus_fixed(bus_fixed),
    .en(en), .start_read_elink(srd_v[0]), .end_read_elink(erd_v[0]), .end_send_msg(esm_v[0]),
    .sign_on_sig(so_v[0]), .irq_elink(irq_v[0]), .payload(pay_v[0]), .canid(canid_v[0]),
    .bus_sel(bus_v[0]), .frame_cnt(fcnt_v[0]), .done(done_v[0]), .err_timeout(err_v[0]),
    .state(st_v[0]));

  mopshub_frame_gen #(.MODE(1), .N_FRAMES(4)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .loop_en(loop_en), .bus_fixed(bus_fixed),
    .en(en), .start_read_elink(srd_v[1]), .end_read_elink(erd_v[1]), .end_send_msg(esm_v[1]),
    .sign_on_sig(so_v[1]), .irq_elink(irq_v[1]), .payload(pay_v[1]), .canid(canid_v[1]),
    .bus_sel(bus_v[1]), .frame_cnt(fcnt_v[1]), .done(done_v[1]), .err_timeout(err_v[1]),
    .state(st_v[1]));

  mopshub_frame_gen #(.N_FRAMES(2)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .loop_en(loop_en), .bus_fixed(bus_fixed),
    .en(en), .start_read_elink(srd_v[2]), .end_read_elink(erd_v[2]), .end_send_msg(esm_v[2]),
    .sign_on_sig(so_v[2]), .irq_elink(irq_v[2]), .payload(pay_v[2]), .canid(canid_v[2]),
    .bus_sel(bus_v[2]), .frame_cnt(fcnt_v[2]), .done(done_v[2]), .err_timeout(err_v[2]),
    .state(st_v[2]));

  always @(negedge clk) if (so_v[2] === 1'b1) so_cnt2++;

  task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input int i);
    check("rst_irq",   76'(irq_v[i]),   76'd0);
    check("rst_so",    76'(so_v[i]),    76'd0);
    check("rst_pay",   pay_v[i],        76'd0);
    check("rst_canid", 76'(canid_v[i]), 76'd0);
    check("rst_bus",   76'(bus_v[i]),   76'd0);
    check("rst_fcnt",  76'(fcnt_v[i]),  76'd0);
    check("rst_done",  76'(done_v[i]),  76'd0);
    check("rst_err",   76'(err_v[i]),   76'd0);
    check("rst_state", 76'(st_v[i]),    76'(IDLE));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_irq(input int i);
    int t;
    t = 0;
    while (irq_v[i] !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("irq_wait", 76'(irq_v[i]), 76'd1);
  endtask

  // core model: answers each handshake step after 3 cycles
  task automatic serve(input int i, output logic [4:0] b, output logic [75:0] p);
    wait_irq(i);
    b = bus_v[i];
    p = pay_v[i];
    repeat (3) @(negedge clk);
    srd_v[i] = 1'b1;
    @(negedge clk);
    srd_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    erd_v[i] = 1'b1;
    @(negedge clk);
    erd_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    esm_v[i] = 1'b1;
    @(negedge clk);
    esm_v[i] = 1'b0;
  endtask

  task automatic serve_check(input int i, output logic [75:0] p);
    logic [4:0]  b;
    logic [4:0]  eb;
    logic [15:0] es;
    eb = exp_q.pop_front();
    es = seq_q.pop_front();
    serve(i, b, p);
    check("bus_sel", 76'(b), 76'(eb));
    check("pay_bus", 76'(p[75:71]), 76'(eb));
    check("pay_seq", 76'(p[15:0]), 76'(es));
    check("pay_cob", 76'(p[70:60]), 76'h601);
  endtask

  task automatic run_rr_pass();
    logic [75:0] p;
    for (int f = 0; f < 16; f++) begin
      exp_q.push_back(5'(f % 8));
      seq_q.push_back(16'(f));
    end
    for (int f = 0; f < 16; f++) begin
      serve_check(0, p);
      if (f == 5) begin
        check("f5_low56", 76'(p[55:0]), 76'h40_1000_0000_0005);
        check("f5_full", p, {5'd5, 11'h601, 4'd8, 56'h40_1000_0000_0005});
        check("f5_canid", 76'(canid_v[0]), 76'h601);
      end
    end
    repeat (3) @(negedge clk);
    check("pass_done", 76'(done_v[0]), 76'd1);
    check("pass_fcnt", 76'(fcnt_v[0]), 76'd16);
  endtask

  initial begin
    logic [75:0] p;
    rst = 1'b1;
    en = 1'b1;
    loop_en = 1'b0;
    bus_fixed = 5'd0;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      srd_v[i] = 1'b0;
      erd_v[i] = 1'b0;
      esm_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    rst = 1'b0;
    @(negedge clk);

    // sign-on sweep, first-frame latency, full round-robin pass
    pulse_start(0);
    for (int k = 0; k < 8; k++) begin
      check("so_pulse", 76'(so_v[0]), 76'd1);
      check("so_bus", 76'(bus_v[0]), 76'(k));
      @(negedge clk);
    end
    check("so_end", 76'(so_v[0]), 76'd0);
    check("lat_irq0", 76'(irq_v[0]), 76'd0);
    @(negedge clk);
    check("lat_irq1", 76'(irq_v[0]), 76'd1);
    run_rr_pass();

    // core withholds end_send_msg: timeout after 16 ACK cycles, same frame re-offered
    pulse_start(0);
    check("err_clr", 76'(err_v[0]), 76'd0);
    wait_irq(0);
    repeat (3) @(negedge clk);
    srd_v[0] = 1'b1;
    @(negedge clk);
    srd_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    erd_v[0] = 1'b1;
    @(negedge clk);
    erd_v[0] = 1'b0;
    check("to_in_ack", 76'(st_v[0]), 76'(ACK));
    repeat (15) @(negedge clk);
    check("to_early", 76'(err_v[0]), 76'd0);
    @(negedge clk);
    check("to_set", 76'(err_v[0]), 76'd1);
    check("to_irq_low", 76'(irq_v[0]), 76'd0);
    check("to_load", 76'(st_v[0]), 76'(LOAD));
    @(negedge clk);
    check("to_reirq", 76'(irq_v[0]), 76'd1);
    check("to_seq", 76'(pay_v[0][15:0]), 76'd0);
    check("to_bus", 76'(bus_v[0]), 76'd0);
    check("to_fcnt", 76'(fcnt_v[0]), 76'd0);

    // reset while in READ, then a fresh pass
    srd_v[0] = 1'b1;
    @(negedge clk);
    srd_v[0] = 1'b0;
    check("in_read", 76'(st_v[0]), 76'(READ));
    rst = 1'b1;
    @(negedge clk);
    check_reset(0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(0);
    run_rr_pass();

    // en held low in LOAD, then simultaneous completions
    en = 1'b0;
    pulse_start(0);
    repeat (58) @(negedge clk);
    check("hold_state", 76'(st_v[0]), 76'(LOAD));
    check("hold_irq", 76'(irq_v[0]), 76'd0);
    check("hold_err", 76'(err_v[0]), 76'd0);
    en = 1'b1;
    wait_irq(0);
    srd_v[0] = 1'b1;
    erd_v[0] = 1'b1;
    @(negedge clk);
    srd_v[0] = 1'b0;
    erd_v[0] = 1'b0;
    check("irq2ack", 76'(st_v[0]), 76'(ACK));
    check("irq2ack_irq", 76'(irq_v[0]), 76'd0);
    esm_v[0] = 1'b1;
    @(negedge clk);
    esm_v[0] = 1'b0;
    check("ack_fcnt", 76'(fcnt_v[0]), 76'd1);
    wait_irq(0);
    check("f1_bus", 76'(bus_v[0]), 76'd1);
    srd_v[0] = 1'b1;
    @(negedge clk);
    srd_v[0] = 1'b0;
    erd_v[0] = 1'b1;
    esm_v[0] = 1'b1;
    @(negedge clk);
    erd_v[0] = 1'b0;
    esm_v[0] = 1'b0;
    check("read2next", 76'(st_v[0]), 76'(NEXT));
    check("read2next_fcnt", 76'(fcnt_v[0]), 76'd2);

    // fixed-bus mode: 11 mod 8 = 3 on every frame
    do_reset();
    bus_fixed = 5'd11;
    pulse_start(1);
    for (int f = 0; f < 4; f++) begin
      exp_q.push_back(5'd3);
      seq_q.push_back(16'(f));
    end
    for (int f = 0; f < 4; f++) serve_check(1, p);
    repeat (3) @(negedge clk);
    check("fix_done", 76'(done_v[1]), 76'd1);
    check("fix_fcnt", 76'(fcnt_v[1]), 76'd4);

    // loop mode with two frames per pass
    do_reset();
    so_cnt2 = 0;
    loop_en = 1'b1;
    pulse_start(2);
    for (int f = 0; f < 6; f++) begin
      exp_q.push_back(5'(f % 2));
      seq_q.push_back(16'(f % 2));
    end
    for (int f = 0; f < 6; f++) begin
      serve_check(2, p);
      check("loop_done", 76'(done_v[2]), 76'd0);
    end
    check("loop_signon", 76'(so_cnt2), 76'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
